// File: rtl/axi_lite_rd_xbar.sv
// AXI4-Lite read-channel crossbar, N masters x M slaves.
// Base/mask decode, round-robin arbitration per slave, one outstanding read per master, DECERR for unmapped addresses.
//
// Slave-side FSM (one per slave):
//   state  | meaning
//   R_IDLE | no grant; pick a requester round-robin
//   R_ADDR | AR forwarded to the slave for the granted master
//   R_DATA | R routed back from the slave to the granted master
// DECERR responder (one per master):
//   D_IDLE | waiting for an unmapped request
//   D_RESP | returning rresp=DECERR, rdata=0
module axi_lite_rd_xbar #(
   parameter int N_MASTERS  = 2,
   parameter int M_SLAVES   = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [M_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h0000_1000, 32'h0000_0000},
   parameter logic [M_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {2{32'hFFFF_F000}}
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]  s_araddr,
   input  logic [N_MASTERS-1:0]             s_arvalid,
   output logic [N_MASTERS-1:0]             s_arready,
   output logic [N_MASTERS*DATA_WIDTH-1:0]  s_rdata,
   output logic [N_MASTERS*2-1:0]           s_rresp,
   output logic [N_MASTERS-1:0]             s_rvalid,
   input  logic [N_MASTERS-1:0]             s_rready,
   output logic [M_SLAVES*ADDR_WIDTH-1:0]   m_araddr,
   output logic [M_SLAVES-1:0]              m_arvalid,
   input  logic [M_SLAVES-1:0]              m_arready,
   input  logic [M_SLAVES*DATA_WIDTH-1:0]   m_rdata,
   input  logic [M_SLAVES*2-1:0]            m_rresp,
   input  logic [M_SLAVES-1:0]              m_rvalid,
   output logic [M_SLAVES-1:0]              m_rready
);

   localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int SW = (M_SLAVES > 1) ? $clog2(M_SLAVES) : 1;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
   typedef enum logic {D_IDLE, D_RESP} d_state_e;

   r_state_e         r_state_q [M_SLAVES];
   r_state_e         r_state_d [M_SLAVES];
   logic [MW-1:0]    grant_q   [M_SLAVES];
   logic [MW-1:0]    grant_d   [M_SLAVES];
   logic [MW-1:0]    ptr_q     [M_SLAVES];
   logic [MW-1:0]    ptr_d     [M_SLAVES];
   d_state_e         d_state_q [N_MASTERS];
   d_state_e         d_state_d [N_MASTERS];
   logic [N_MASTERS-1:0] pend_q, pend_d;

   logic             hit [N_MASTERS];
   logic [SW-1:0]    sel [N_MASTERS];
   logic             found;
   logic [MW:0]      sum;
   logic [MW-1:0]    cand;
   logic [MW-1:0]    g;

   // Descending scan so the lowest matching slave index wins on overlap.
   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         hit[i] = 1'b0;
         sel[i] = '0;
         for (int j = M_SLAVES-1; j >= 0; j--) begin
            if ((s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[j*ADDR_WIDTH +: ADDR_WIDTH])
                == SLAVE_BASE[j*ADDR_WIDTH +: ADDR_WIDTH]) begin
               hit[i] = 1'b1;
               sel[i] = SW'(j);
            end
         end
      end
   end

   always_comb begin
      s_arready = '0;
      s_rdata   = '0;
      s_rresp   = '0;
      s_rvalid  = '0;
      m_araddr  = '0;
      m_arvalid = '0;
      m_rready  = '0;
      pend_d    = pend_q;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      g         = '0;
      for (int j = 0; j < M_SLAVES; j++) begin
         r_state_d[j] = r_state_q[j];
         grant_d[j]   = grant_q[j];
         ptr_d[j]     = ptr_q[j];
      end
      for (int i = 0; i < N_MASTERS; i++) d_state_d[i] = d_state_q[i];

      for (int j = 0; j < M_SLAVES; j++) begin
         g = grant_q[j];
         case (r_state_q[j])
            R_IDLE: begin
               found = 1'b0;
               for (int k = 0; k < N_MASTERS; k++) begin
                  sum = {1'b0, ptr_q[j]} + (MW+1)'(k);
                  if (sum >= (MW+1)'(N_MASTERS)) sum = sum - (MW+1)'(N_MASTERS);
                  cand = sum[MW-1:0];
                  if (!found && s_arvalid[cand] && !pend_q[cand] && hit[cand] && sel[cand] == SW'(j)) begin
                     found      = 1'b1;
                     grant_d[j] = cand;
                  end
               end
               if (found) r_state_d[j] = R_ADDR;
            end
            R_ADDR: begin
               m_arvalid[j] = 1'b1;
               m_araddr[j*ADDR_WIDTH +: ADDR_WIDTH] = s_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
               s_arready[g] = m_arready[j];
               if (m_arready[j]) r_state_d[j] = R_DATA;
            end
            R_DATA: begin
               s_rvalid[g] = m_rvalid[j];
               s_rdata[g*DATA_WIDTH +: DATA_WIDTH] = m_rdata[j*DATA_WIDTH +: DATA_WIDTH];
               s_rresp[g*2 +: 2] = m_rresp[j*2 +: 2];
               m_rready[j] = s_rready[g];
               if (m_rvalid[j] && s_rready[g]) begin
                  r_state_d[j] = R_IDLE;
                  ptr_d[j]     = (g == MW'(N_MASTERS-1)) ? '0 : g + 1'b1;
               end
            end
            default: r_state_d[j] = R_IDLE;
         endcase
      end

      // The combinational accept is gated by reset so every output reads 0 while aresetn is low.
      for (int i = 0; i < N_MASTERS; i++) begin
         case (d_state_q[i])
            D_IDLE: begin
               if (aresetn && s_arvalid[i] && !pend_q[i] && !hit[i]) begin
                  s_arready[i] = 1'b1;
                  d_state_d[i] = D_RESP;
               end
            end
            D_RESP: begin
               s_rvalid[i]       = 1'b1;
               s_rresp[i*2 +: 2] = 2'b11;
               if (s_rready[i]) d_state_d[i] = D_IDLE;
            end
            default: d_state_d[i] = D_IDLE;
         endcase
      end

      for (int i = 0; i < N_MASTERS; i++) begin
         if (s_arvalid[i] && s_arready[i])   pend_d[i] = 1'b1;
         else if (s_rvalid[i] && s_rready[i]) pend_d[i] = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pend_q <= '0;
         for (int j = 0; j < M_SLAVES; j++) begin
            r_state_q[j] <= R_IDLE;
            grant_q[j]   <= '0;
            ptr_q[j]     <= '0;
         end
         for (int i = 0; i < N_MASTERS; i++) d_state_q[i] <= D_IDLE;
      end else begin
         pend_q <= pend_d;
         for (int j = 0; j < M_SLAVES; j++) begin
            r_state_q[j] <= r_state_d[j];
            grant_q[j]   <= grant_d[j];
            ptr_q[j]     <= ptr_d[j];
         end
         for (int i = 0; i < N_MASTERS; i++) d_state_q[i] <= d_state_d[i];
      end
   end

endmodule

// File: tb/tb_axi_lite_rd_xbar.sv
// Bench for axi_lite_rd_xbar: directed timing scenarios plus randomized traffic
// scored against an address-map reference model.
module tb_axi_lite_rd_xbar;
   localparam int N  = 2;
   localparam int M  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic [N*AW-1:0] s_araddr;
   logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
   logic [N*DW-1:0] s_rdata;
   logic [2*N-1:0]  s_rresp;
   logic [M*AW-1:0] m_araddr;
   logic [M-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
   logic [M*DW-1:0] m_rdata;
   logic [2*M-1:0]  m_rresp;

   axi_lite_rd_xbar dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Address map of the default configuration: slave0 at 0x0000_0xxx, slave1 at 0x0000_1xxx.
   function automatic int ref_dec(input logic [31:0] a);
      logic [31:0] base [2];
      base[0] = 32'h0000_0000;
      base[1] = 32'h0000_1000;
      for (int j = 0; j < M; j++)
         if ((a & 32'hFFFF_F000) == base[j]) return j;
      return -1;
   endfunction

   function automatic logic [31:0] ref_data(input int j, input logic [31:0] a);
      if (j < 0) return 32'h0;
      return a ^ 32'hDEADBEFF ^ (32'(j) << 28);
   endfunction

   function automatic logic [1:0] ref_resp(input int j, input logic [31:0] a);
      if (j < 0) return 2'b11;
      return (a[3:2] == 2'b11) ? 2'b10 : 2'b00;
   endfunction

   logic [31:0] req_q [N][$];
   logic [31:0] out_q [N][$];
   int          ar_log [$];
   int          ar_cyc [M][$];
   int          rr_mode [N];
   bit          rnd = 1'b0;
   int          n_rdone = 0;

   int          sst [M];
   int          scnt [M];
   logic [31:0] saddr [M];
   bit          ar_hs_s [N];
   bit          r_hs_m [M];
   bit          ar_hs_m [M];
   logic [31:0] cap_maddr [M];

   function automatic int dly();
      return rnd ? int'($urandom_range(0, 3)) : 0;
   endfunction

   function automatic bit idle();
      for (int i = 0; i < N; i++)
         if (req_q[i].size() != 0 || out_q[i].size() != 0 || s_arvalid[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Master and slave agents: observe handshakes at negedge, update drive at posedge+1.
   initial begin
      logic [31:0] a;
      int j;
      s_arvalid = '0; s_araddr = '0; s_rready = '0;
      m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0;
      for (int k = 0; k < M; k++) begin sst[k] = 0; scnt[k] = 0; saddr[k] = '0; end
      forever begin
         @(negedge aclk);
         for (int i = 0; i < N; i++) begin
            ar_hs_s[i] = s_arvalid[i] && s_arready[i];
            if (ar_hs_s[i]) ar_log.push_back(i);
            if (s_rvalid[i] && s_rready[i]) begin
               chk("r_outstanding", 64'(out_q[i].size()), 64'd1);
               if (out_q[i].size() > 0) begin
                  a = out_q[i].pop_front();
                  j = ref_dec(a);
                  chk("rdata", 64'(s_rdata[i*DW +: DW]), 64'(ref_data(j, a)));
                  chk("rresp", 64'(s_rresp[i*2 +: 2]), 64'(ref_resp(j, a)));
                  n_rdone++;
               end
            end
         end
         for (int k = 0; k < M; k++) begin
            ar_hs_m[k]   = m_arvalid[k] && m_arready[k];
            r_hs_m[k]    = m_rvalid[k] && m_rready[k];
            cap_maddr[k] = m_araddr[k*AW +: AW];
            if (ar_hs_m[k]) begin
               chk("m_ar_decode", 64'(ref_dec(cap_maddr[k])), 64'(k));
               ar_cyc[k].push_back(cyc);
            end
         end
         @(posedge aclk);
         #1;
         if (!aresetn) begin
            s_arvalid = '0; m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0;
            for (int i = 0; i < N; i++) begin req_q[i].delete(); out_q[i].delete(); end
            for (int k = 0; k < M; k++) begin sst[k] = 0; scnt[k] = 0; end
            continue;
         end
         for (int i = 0; i < N; i++) begin
            if (ar_hs_s[i]) begin
               out_q[i].push_back(s_araddr[i*AW +: AW]);
               s_arvalid[i] = 1'b0;
            end
            if (!s_arvalid[i] && req_q[i].size() > 0) begin
               s_araddr[i*AW +: AW] = req_q[i].pop_front();
               s_arvalid[i] = 1'b1;
            end
            s_rready[i] = (rr_mode[i] == 1) ? 1'b1 : (rr_mode[i] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         end
         for (int k = 0; k < M; k++) begin
            if (sst[k] == 0) begin
               if (ar_hs_m[k]) begin sst[k] = 1; scnt[k] = dly(); saddr[k] = cap_maddr[k]; end
               else if (scnt[k] > 0) scnt[k]--;
            end else begin
               if (r_hs_m[k]) begin sst[k] = 0; scnt[k] = dly(); end
               else if (scnt[k] > 0) scnt[k]--;
            end
            m_arready[k] = (sst[k] == 0 && scnt[k] == 0);
            m_rvalid[k]  = (sst[k] == 1 && scnt[k] == 0);
            m_rdata[k*DW +: DW] = m_rvalid[k] ? ref_data(k, saddr[k]) : '0;
            m_rresp[k*2 +: 2]   = m_rvalid[k] ? ref_resp(k, saddr[k]) : 2'b00;
         end
      end
   end

   task automatic wait_idle(input string tag);
      int w = 0;
      while (w < 3000 && !idle()) begin @(negedge aclk); w++; end
      chk(tag, 64'(w < 3000), 64'd1);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
   endtask

   task automatic wait_rvalid0(input string tag);
      int w = 0;
      while (w < 50 && !s_rvalid[0]) begin @(negedge aclk); w++; end
      chk(tag, 64'(w < 50), 64'd1);
   endtask

   initial begin
      int base_done;
      aresetn = 1'b0;
      rr_mode[0] = 1; rr_mode[1] = 1;
      repeat (3) @(negedge aclk);
      chk("reset_outputs", 64'(|{s_arready, s_rdata, s_rresp, s_rvalid, m_araddr, m_arvalid, m_rready}), 64'd0);
      aresetn = 1'b1;
      @(negedge aclk);

      // single read
      req_q[0].push_back(32'h0000_0010);
      @(negedge aclk);
      chk("single_arvalid_T", 64'(s_arvalid[0]), 64'd1);
      chk("single_no_marv_T", 64'(m_arvalid), 64'd0);
      @(negedge aclk);
      chk("single_marv_T1", 64'(m_arvalid), 64'b01);
      chk("single_maddr", 64'(m_araddr[AW-1:0]), 64'h10);
      chk("single_arready", 64'(s_arready[0]), 64'd1);
      @(negedge aclk);
      chk("single_rvalid", 64'(s_rvalid[0]), 64'd1);
      chk("single_rdata", 64'(s_rdata[DW-1:0]), 64'hDEADBEEF);
      chk("single_rresp", 64'(s_rresp[1:0]), 64'd0);
      wait_idle("single_done");

      // contention on slave1 from reset
      do_reset();
      ar_log.delete();
      ar_cyc[1].delete();
      for (int k = 0; k < 4; k++) begin
         req_q[0].push_back(32'h0000_1004);
         req_q[1].push_back(32'h0000_1004);
      end
      wait_idle("contend_done");
      chk("contend_count", 64'(ar_log.size()), 64'd8);
      for (int k = 0; k < ar_log.size(); k++) chk("contend_order", 64'(ar_log[k]), 64'(k % 2));
      for (int k = 1; k < ar_cyc[1].size(); k++)
         chk("contend_gap", 64'(ar_cyc[1][k] - ar_cyc[1][k-1]), 64'd3);

      // parallel reads to different slaves
      req_q[0].push_back(32'h0000_0000);
      req_q[1].push_back(32'h0000_1000);
      @(negedge aclk);
      chk("par_arvalid", 64'(s_arvalid), 64'b11);
      @(negedge aclk);
      chk("par_marvalid", 64'(m_arvalid), 64'b11);
      wait_idle("par_done");

      // decode error
      req_q[1].push_back(32'h0000_8000);
      @(negedge aclk);
      chk("dec_arready", 64'(s_arready[1]), 64'd1);
      chk("dec_no_marv0", 64'(m_arvalid), 64'd0);
      @(negedge aclk);
      chk("dec_rvalid", 64'(s_rvalid[1]), 64'd1);
      chk("dec_rresp", 64'(s_rresp[3:2]), 64'b11);
      chk("dec_rdata", 64'(s_rdata[2*DW-1:DW]), 64'd0);
      chk("dec_no_marv1", 64'(m_arvalid), 64'd0);
      wait_idle("dec_done");

      // backpressure with a second request from the same master
      rr_mode[0] = 2;
      req_q[0].push_back(32'h0000_0020);
      req_q[0].push_back(32'h0000_0024);
      wait_rvalid0("bp_rvalid_seen");
      for (int k = 0; k < 5; k++) begin
         chk("bp_mrready", 64'(m_rready[0]), 64'd0);
         chk("bp_rdata_held", 64'(s_rdata[DW-1:0]), 64'(ref_data(0, 32'h20)));
         chk("bp_second_arvalid", 64'(s_arvalid[0]), 64'd1);
         chk("bp_arready_blocked", 64'(s_arready[0]), 64'd0);
         @(negedge aclk);
      end
      rr_mode[0] = 1;
      wait_idle("bp_done");

      // reset in the middle of R_DATA
      rr_mode[0] = 2;
      req_q[0].push_back(32'h0000_0030);
      wait_rvalid0("rst_rvalid_seen");
      aresetn = 1'b0;
      #1;
      chk("rst_mid_outputs", 64'(|{s_arready, s_rdata, s_rresp, s_rvalid, m_araddr, m_arvalid, m_rready}), 64'd0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      rr_mode[0] = 1;
      @(negedge aclk);
      base_done = n_rdone;
      req_q[1].push_back(32'h0000_0040);
      wait_idle("rst_after_done");
      chk("rst_after_count", 64'(n_rdone - base_done), 64'd1);

      // randomized traffic
      rnd = 1'b1;
      rr_mode[0] = 0; rr_mode[1] = 0;
      base_done = n_rdone;
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 2))
               0:       req_q[i].push_back({20'h0, 10'($urandom), 2'b00});
               1:       req_q[i].push_back({20'h1, 10'($urandom), 2'b00});
               default: req_q[i].push_back($urandom | 32'h0001_0000);
            endcase
         end
      end
      wait_idle("rand_done");
      chk("rand_count", 64'(n_rdone - base_done), 64'd80);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
